// File: rtl/music_seq.sv
// Score sequencer: walks an external synchronous score ROM one entry per beat and
// drives note dividers and a volume code for a two-channel note generator.
module music_seq #(
   parameter int BEAT_DIV   = 12_500_000,
   parameter int GAP_CYCLES = 1_250_000,
   parameter int SCORE_LEN  = 512,
   localparam int ADDR_W    = $clog2(SCORE_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              play,
   input  logic              stop,
   input  logic              loop,
   input  logic              vol_up,
   input  logic              vol_down,
   input  logic              mute,
   output logic [ADDR_W-1:0] score_addr,
   input  logic [43:0]       score_data,
   output logic [21:0]       note_div_left,
   output logic [21:0]       note_div_right,
   output logic [3:0]        volume,
   output logic              playing,
   output logic              done
);

   localparam int BCNT_W = $clog2(BEAT_DIV);
   localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEAT_DIV - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(SCORE_LEN - 1);
   localparam int GAP_START = BEAT_DIV - GAP_CYCLES;

   typedef enum logic [2:0] {IDLE, LOAD, PLAY, PAUSE, DONE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   idx;
   logic [BCNT_W-1:0]   beat_cnt;
   logic                load_cnt;
   logic [21:0]         cur_l;
   logic [21:0]         cur_r;
   logic [2:0]          level;

   logic                beat_end;
   logic                idx_last;
   logic                terminal;
   logic [ADDR_W-1:0]   idx_next;
   logic                in_gap_zone;
   logic                repeat_note;
   logic                sound_on;

   assign beat_end    = (beat_cnt == BEAT_LAST);
   assign idx_last    = (idx == IDX_LAST);
   assign terminal    = idx_last && !loop;
   assign idx_next    = idx_last ? '0 : idx + ADDR_W'(1);
   assign in_gap_zone = (32'(beat_cnt) >= 32'(GAP_START));
   // score_data already holds the prefetched next entry, so equality means a repeated note
   assign repeat_note = (score_data == {cur_l, cur_r});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         beat_cnt <= '0;
         load_cnt <= 1'b0;
         cur_l    <= 22'd1;
         cur_r    <= 22'd1;
      end else if (stop) begin
         state    <= IDLE;
         idx      <= '0;
         beat_cnt <= '0;
         load_cnt <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (play) begin
                  state    <= LOAD;
                  load_cnt <= 1'b0;
               end
            end
            LOAD: begin
               // first cycle presents address 0, second cycle sees its data
               if (load_cnt) begin
                  state    <= PLAY;
                  cur_l    <= score_data[43:22];
                  cur_r    <= score_data[21:0];
                  idx      <= '0;
                  beat_cnt <= '0;
                  load_cnt <= 1'b0;
               end else begin
                  load_cnt <= 1'b1;
               end
            end
            PLAY: begin
               if (beat_end) begin
                  beat_cnt <= '0;
                  if (terminal) begin
                     state <= DONE;
                  end else begin
                     cur_l <= score_data[43:22];
                     cur_r <= score_data[21:0];
                     idx   <= idx_next;
                     if (!play) state <= PAUSE;
                  end
               end else begin
                  beat_cnt <= beat_cnt + BCNT_W'(1);
                  if (!play) state <= PAUSE;
               end
            end
            PAUSE: begin
               if (play) state <= PLAY;
            end
            DONE: begin
               if (!play) begin
                  state    <= IDLE;
                  idx      <= '0;
                  beat_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         level <= 3'd3;
      else if (vol_up && !vol_down && level != 3'd5)
         level <= level + 3'd1;
      else if (vol_down && !vol_up && level != 3'd1)
         level <= level - 3'd1;
   end

   assign playing    = (state == PLAY);
   assign done       = (state == DONE);
   assign score_addr = (state == PLAY || state == PAUSE) ? idx_next : '0;

   // decoded from state so an asynchronous reset silences the outputs at once
   assign sound_on       = playing && !(in_gap_zone && repeat_note && !terminal);
   assign note_div_left  = (sound_on && cur_l >= 22'd2) ? cur_l : 22'd1;
   assign note_div_right = (sound_on && cur_r >= 22'd2) ? cur_r : 22'd1;
   assign volume         = mute ? 4'd0 : {1'b0, level};

endmodule

// File: tb/tb_music_seq.sv
// Bench for music_seq: directed vector table plus randomized play against a
// position-based reference model of the score walk.
module tb_music_seq;
   localparam int BD  = 8;
   localparam int GP  = 2;
   localparam int SL  = 4;
   localparam int AW  = 2;
   localparam int TOT = SL * BD;
   localparam logic [21:0] A = 22'd100;
   localparam logic [21:0] B = 22'd200;
   localparam logic [21:0] C = 22'd300;

   localparam int MD_IDLE  = 0;
   localparam int MD_LOAD  = 1;
   localparam int MD_PLAY  = 2;
   localparam int MD_PAUSE = 3;
   localparam int MD_DONE  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          play, stop, loop, vol_up, vol_down, mute;
   logic [AW-1:0] score_addr;
   logic [43:0]   score_data;
   logic [21:0]   note_div_left, note_div_right;
   logic [3:0]    volume;
   logic          playing, done;
   logic [43:0]   rom [SL];
   logic [51:0]   obs;

   int checks = 0;
   int errors = 0;
   int m_mode, m_load, m_pos, m_lvl;

   music_seq #(.BEAT_DIV(BD), .GAP_CYCLES(GP), .SCORE_LEN(SL)) dut (
      .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .loop(loop),
      .vol_up(vol_up), .vol_down(vol_down), .mute(mute),
      .score_addr(score_addr), .score_data(score_data),
      .note_div_left(note_div_left), .note_div_right(note_div_right),
      .volume(volume), .playing(playing), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) score_data <= rom[score_addr];

   assign obs = {score_addr, note_div_left, note_div_right, volume, playing, done};

   typedef struct {
      logic play, stop, lp, up, down, mute;
      int   n;
      logic [AW-1:0] e_addr;
      logic [21:0]   e_l, e_r;
      logic [3:0]    e_vol;
      logic          e_pl, e_done;
   } vec_t;

   vec_t tbl [35];

   function automatic vec_t mk(input logic p, s, lp, up, dn, mu, input int n,
                               input logic [AW-1:0] a, input logic [21:0] l, r,
                               input logic [3:0] v, input logic pl, dne);
      vec_t t;
      t.play = p; t.stop = s; t.lp = lp; t.up = up; t.down = dn; t.mute = mu; t.n = n;
      t.e_addr = a; t.e_l = l; t.e_r = r; t.e_vol = v; t.e_pl = pl; t.e_done = dne;
      return t;
   endfunction

   task automatic check(input string nm, input int id, input logic [51:0] act, input logic [51:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h (addr,l,r,vol,playing,done)", nm, id, act, exp);
      end
   endtask

   function automatic logic [21:0] clampd(input logic [21:0] v);
      return (v < 22'd2) ? 22'd1 : v;
   endfunction

   // Expected outputs from the model's score position and the current level inputs
   function automatic logic [51:0] model_out(input logic lp, input logic mu);
      int e   = m_pos / BD;
      int ph  = m_pos % BD;
      int nx  = (e + 1) % SL;
      logic run  = (m_mode == MD_PLAY);
      logic term = (e == SL - 1) && !lp;
      logic gap  = run && (ph >= BD - GP) && (rom[nx] == rom[e]) && !term;
      logic [43:0]   ent = rom[e];
      logic [AW-1:0] a   = (m_mode == MD_PLAY || m_mode == MD_PAUSE) ? AW'(nx) : '0;
      logic [21:0]   l   = (run && !gap) ? clampd(ent[43:22]) : 22'd1;
      logic [21:0]   r   = (run && !gap) ? clampd(ent[21:0]) : 22'd1;
      logic [3:0]    v   = mu ? 4'd0 : 4'(m_lvl);
      return {a, l, r, v, run, (m_mode == MD_DONE)};
   endfunction

   task automatic model_reset();
      m_mode = MD_IDLE; m_pos = 0; m_load = 0; m_lvl = 3;
   endtask

   task automatic model_advance(input logic p, s, lp, up, dn);
      if (up && !dn && m_lvl < 5) m_lvl++;
      if (dn && !up && m_lvl > 1) m_lvl--;
      if (s) begin
         m_mode = MD_IDLE; m_pos = 0; m_load = 0;
      end else if (m_mode == MD_IDLE) begin
         if (p) begin m_mode = MD_LOAD; m_load = 0; end
      end else if (m_mode == MD_LOAD) begin
         if (m_load == 1) begin m_mode = MD_PLAY; m_pos = 0; end
         else m_load = 1;
      end else if (m_mode == MD_PLAY) begin
         if (m_pos == TOT - 1 && !lp) begin
            m_mode = MD_DONE; m_pos = 0;
         end else begin
            m_pos = (m_pos + 1) % TOT;
            if (!p) m_mode = MD_PAUSE;
         end
      end else if (m_mode == MD_PAUSE) begin
         if (p) m_mode = MD_PLAY;
      end else if (m_mode == MD_DONE) begin
         if (!p) begin m_mode = MD_IDLE; m_pos = 0; end
      end
   endtask

   task automatic step(input logic p, s, lp, up, dn, mu);
      @(negedge clk);
      play = p; stop = s; loop = lp; vol_up = up; vol_down = dn; mute = mu;
      #1;
      check("model", m_mode * 1000 + m_pos, obs, model_out(lp, mu));
      model_advance(p, s, lp, up, dn);
   endtask

   function automatic logic [21:0] rnd_div();
      int k = int'($urandom_range(0, 3));
      if (k == 0) return 22'd0;
      if (k == 1) return 22'd1;
      if (k == 2) return 22'd2;
      return 22'($urandom_range(3, 5000));
   endfunction

   initial begin
      play = 0; stop = 0; loop = 0; vol_up = 0; vol_down = 0; mute = 0;
      rom[0] = {A, A}; rom[1] = {B, B}; rom[2] = {B, B}; rom[3] = {22'd0, C};
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check("reset", 0, obs, {2'd0, 22'd1, 22'd1, 4'd3, 1'b0, 1'b0});
      mute = 1;
      #1 check("reset_mute", 0, obs, {2'd0, 22'd1, 22'd1, 4'd0, 1'b0, 1'b0});
      mute = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      //            play stop lp up dn mu  n  addr l   r   vol pl dn
      tbl[0]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 3, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0, 0, 0,  2, 0, 1, 1, 3, 0, 0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0,  1, 1, A, A, 3, 1, 0);
      tbl[3]  = mk(1, 0, 0, 0, 0, 0,  7, 1, A, A, 3, 1, 0);
      tbl[4]  = mk(1, 0, 0, 0, 0, 0,  1, 2, B, B, 3, 1, 0);
      tbl[5]  = mk(1, 0, 0, 0, 0, 0,  6, 2, 1, 1, 3, 1, 0);
      tbl[6]  = mk(1, 0, 0, 0, 0, 0,  1, 2, 1, 1, 3, 1, 0);
      tbl[7]  = mk(1, 0, 0, 0, 0, 0,  1, 3, B, B, 3, 1, 0);
      tbl[8]  = mk(1, 0, 0, 0, 0, 0,  7, 3, B, B, 3, 1, 0);
      tbl[9]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 1, C, 3, 1, 0);
      tbl[10] = mk(1, 0, 0, 0, 0, 0,  7, 0, 1, C, 3, 1, 0);
      tbl[11] = mk(1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 3, 0, 1);
      tbl[12] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 3, 0, 1);
      tbl[13] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 3, 0, 0);
      tbl[14] = mk(1, 0, 1, 0, 0, 0,  3, 0, 1, 1, 3, 0, 0);
      tbl[15] = mk(1, 0, 1, 0, 0, 0, 25, 0, 1, C, 3, 1, 0);
      tbl[16] = mk(1, 0, 1, 0, 0, 0,  7, 0, 1, C, 3, 1, 0);
      tbl[17] = mk(1, 0, 1, 0, 0, 0,  1, 1, A, A, 3, 1, 0);
      tbl[18] = mk(1, 0, 1, 0, 0, 0,  2, 1, A, A, 3, 1, 0);
      tbl[19] = mk(0, 0, 1, 0, 0, 0,  1, 1, A, A, 3, 1, 0);
      tbl[20] = mk(0, 0, 1, 0, 0, 0, 20, 1, 1, 1, 3, 0, 0);
      tbl[21] = mk(1, 0, 1, 0, 0, 0,  1, 1, 1, 1, 3, 0, 0);
      tbl[22] = mk(1, 0, 1, 0, 0, 0,  4, 1, A, A, 3, 1, 0);
      tbl[23] = mk(1, 0, 1, 0, 0, 0,  1, 2, B, B, 3, 1, 0);
      tbl[24] = mk(1, 0, 1, 0, 0, 0,  6, 2, 1, 1, 3, 1, 0);
      tbl[25] = mk(1, 1, 1, 0, 0, 0,  1, 2, 1, 1, 3, 1, 0);
      tbl[26] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 3, 0, 0);
      tbl[27] = mk(0, 0, 0, 1, 0, 0,  3, 0, 1, 1, 5, 0, 0);
      tbl[28] = mk(0, 0, 0, 1, 1, 0,  1, 0, 1, 1, 5, 0, 0);
      tbl[29] = mk(0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0);
      tbl[30] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 5, 0, 0);
      tbl[31] = mk(0, 0, 0, 0, 1, 0,  5, 0, 1, 1, 1, 0, 0);
      tbl[32] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 1, 0, 0);
      tbl[33] = mk(0, 0, 0, 1, 0, 1,  1, 0, 1, 1, 0, 0, 0);
      tbl[34] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 2, 0, 0);

      for (int i = 0; i < 35; i++) begin
         for (int k = 0; k < tbl[i].n; k++)
            step(tbl[i].play, tbl[i].stop, tbl[i].lp, tbl[i].up, tbl[i].down, tbl[i].mute);
         check("row", i, obs, {tbl[i].e_addr, tbl[i].e_l, tbl[i].e_r, tbl[i].e_vol, tbl[i].e_pl, tbl[i].e_done});
      end

      // asynchronous reset in the middle of a beat
      repeat (5) step(1, 0, 0, 0, 0, 0);
      check("pre_reset_playing", 0, 52'(playing), 52'd1);
      rst_n = 1'b0;
      #1 check("async_reset", 0, obs, {2'd0, 22'd1, 22'd1, 4'd3, 1'b0, 1'b0});
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int seg = 0; seg < 10; seg++) begin
         logic lp;
         step(0, 1, 0, 0, 0, 0);
         for (int i = 0; i < SL; i++) begin
            if (i > 0 && $urandom_range(0, 2) == 0) rom[i] = rom[i-1];
            else rom[i] = {rnd_div(), rnd_div()};
         end
         lp = 1'($urandom_range(0, 1));
         for (int c = 0; c < 300; c++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 63) == 0, lp,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
